// File: rtl/color_conv_engine.sv
// Streaming colour-space converter: 3-stage multiply / sum / round-offset-saturate
// pipeline with built-in BT.601 matrices and a programmable custom matrix.
module color_conv_engine #(
  parameter int PIX_PER_BEAT = 4,
  parameter int CH_WIDTH     = 8,
  parameter int COEF_WIDTH   = 10,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                clear_i,
  input  logic                                start_i,
  input  logic [1:0]                          mode_i,
  input  logic [LEN_WIDTH-1:0]                len_i,
  input  logic [9*COEF_WIDTH-1:0]             coef_i,
  input  logic [3*CH_WIDTH+2:0]               in_off_i,
  input  logic [3*CH_WIDTH+2:0]               out_off_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [PIX_PER_BEAT*3*CH_WIDTH-1:0]  in_data_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [PIX_PER_BEAT*3*CH_WIDTH-1:0]  out_data_o,
  output logic                                busy_o,
  output logic                                done_o
);

  localparam int FRAC   = COEF_WIDTH - 2;
  localparam int OFF_W  = CH_WIDTH + 1;
  localparam int X_W    = CH_WIDTH + 2;
  localparam int PROD_W = CH_WIDTH + COEF_WIDTH + 1;
  localparam int ACC_W  = PROD_W + 2;
  localparam int DATA_W = PIX_PER_BEAT * 3 * CH_WIDTH;
  localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** CH_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e state, next_state;

  logic signed [COEF_WIDTH-1:0] coef_q [9];
  logic signed [COEF_WIDTH-1:0] coef_sel [9];
  logic signed [OFF_W-1:0]      in_off_q [3];
  logic signed [OFF_W-1:0]      out_off_q [3];
  logic signed [OFF_W-1:0]      in_off_sel [3];
  logic signed [OFF_W-1:0]      out_off_sel [3];
  logic [LEN_WIDTH-1:0]         len_q, in_cnt, out_cnt;
  logic                         rst, en, in_hs, out_hs, v1, v2;

  logic signed [PROD_W-1:0] prod_q [PIX_PER_BEAT][9];
  logic signed [PROD_W-1:0] prod_d [PIX_PER_BEAT][9];
  logic signed [ACC_W-1:0]  acc_q [PIX_PER_BEAT][3];
  logic signed [ACC_W-1:0]  acc_d [PIX_PER_BEAT][3];
  logic [DATA_W-1:0]        res_d;

  function automatic logic signed [COEF_WIDTH-1:0] cf(input int v);
    return COEF_WIDTH'(v);
  endfunction

  function automatic logic signed [OFF_W-1:0] off_c(input int v);
    return OFF_W'(v);
  endfunction

  assign rst        = rst_i || clear_i;
  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = (state == RUN) && (in_cnt < len_q) && en;
  assign in_hs      = in_valid_i && in_ready_o;
  assign out_hs     = out_valid_o && out_ready_i;

  // Every mode is reduced to a matrix plus offsets at start, so the datapath has no mode logic.
  always_comb begin
    for (int i = 0; i < 9; i++) coef_sel[i] = '0;
    for (int k = 0; k < 3; k++) begin
      in_off_sel[k]  = '0;
      out_off_sel[k] = '0;
    end
    case (mode_i)
      2'd0: begin
        coef_sel[0] = cf(256); coef_sel[4] = cf(256); coef_sel[8] = cf(256);
      end
      2'd1: begin
        coef_sel[0] = cf(77);  coef_sel[1] = cf(150);  coef_sel[2] = cf(29);
        coef_sel[3] = cf(-43); coef_sel[4] = cf(-85);  coef_sel[5] = cf(128);
        coef_sel[6] = cf(128); coef_sel[7] = cf(-107); coef_sel[8] = cf(-21);
        out_off_sel[1] = off_c(128); out_off_sel[2] = off_c(128);
      end
      2'd2: begin
        coef_sel[0] = cf(256); coef_sel[1] = cf(0);   coef_sel[2] = cf(359);
        coef_sel[3] = cf(256); coef_sel[4] = cf(-88); coef_sel[5] = cf(-183);
        coef_sel[6] = cf(256); coef_sel[7] = cf(454); coef_sel[8] = cf(0);
        in_off_sel[1] = off_c(-128); in_off_sel[2] = off_c(-128);
      end
      default: begin
        for (int i = 0; i < 9; i++) coef_sel[i] = coef_i[i*COEF_WIDTH +: COEF_WIDTH];
        for (int k = 0; k < 3; k++) begin
          in_off_sel[k]  = in_off_i[k*OFF_W +: OFF_W];
          out_off_sel[k] = out_off_i[k*OFF_W +: OFF_W];
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (state == IDLE && start_i) begin
      coef_q    <= coef_sel;
      in_off_q  <= in_off_sel;
      out_off_q <= out_off_sel;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_i) next_state = (len_i == '0) ? DONE : RUN;
      RUN:     if (in_hs && (in_cnt + LEN_WIDTH'(1) == len_q)) next_state = DRAIN;
      DRAIN:   if (out_cnt + LEN_WIDTH'(out_hs) == len_q) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // done_o fires the cycle after the final output handshake; an empty job reports one cycle after DONE.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state  <= next_state;
      busy_o <= (next_state == RUN) || (next_state == DRAIN);
      done_o <= ((state == DRAIN) && (next_state == DONE)) || ((state == DONE) && (len_q == '0));
      if (state == IDLE && start_i) begin
        len_q   <= len_i;
        in_cnt  <= '0;
        out_cnt <= '0;
      end else begin
        if (in_hs)  in_cnt  <= in_cnt + LEN_WIDTH'(1);
        if (out_hs) out_cnt <= out_cnt + LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    logic signed [X_W-1:0] xo;
    xo = '0;
    for (int p = 0; p < PIX_PER_BEAT; p++) begin
      for (int k = 0; k < 3; k++) begin
        xo = $signed({2'b00, in_data_i[(3*p+k)*CH_WIDTH +: CH_WIDTH]}) + X_W'(in_off_q[k]);
        for (int r = 0; r < 3; r++) prod_d[p][3*r+k] = PROD_W'(xo) * PROD_W'(coef_q[3*r+k]);
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PIX_PER_BEAT; p++)
      for (int r = 0; r < 3; r++)
        acc_d[p][r] = ACC_W'(prod_q[p][3*r]) + ACC_W'(prod_q[p][3*r+1])
                    + ACC_W'(prod_q[p][3*r+2]) + ROUND;
  end

  always_comb begin
    logic signed [ACC_W-1:0] y;
    y     = '0;
    res_d = '0;
    for (int p = 0; p < PIX_PER_BEAT; p++) begin
      for (int r = 0; r < 3; r++) begin
        y = (acc_q[p][r] >>> FRAC) + ACC_W'(out_off_q[r]);
        if (y < 0)          res_d[(3*p+r)*CH_WIDTH +: CH_WIDTH] = '0;
        else if (y > Y_MAX) res_d[(3*p+r)*CH_WIDTH +: CH_WIDTH] = '1;
        else                res_d[(3*p+r)*CH_WIDTH +: CH_WIDTH] = y[CH_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (en) begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  // A single enable freezes the whole pipe, so a stalled output holds its data.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (en) begin
      v1          <= in_hs;
      v2          <= v1;
      out_valid_o <= v2;
      out_data_o  <= res_d;
    end
  end

endmodule

// File: tb/tb_color_conv_engine.sv
// Self-checking bench for color_conv_engine: directed jobs with random pixel data,
// checked against an integer reference of the conversion arithmetic.
module tb_color_conv_engine;

  localparam int NP = 4;
  localparam int CW = 8;
  localparam int KW = 10;
  localparam int LW = 16;
  localparam int DW = NP * 3 * CW;
  localparam int OW = CW + 1;

  logic           clk_i = 1'b0;
  logic           rst_i, clear_i, start_i;
  logic [1:0]     mode_i;
  logic [LW-1:0]  len_i;
  logic [9*KW-1:0] coef_i;
  logic [3*CW+2:0] in_off_i, out_off_i;
  logic           in_valid_i, in_ready_o;
  logic [DW-1:0]  in_data_i;
  logic           out_valid_o, out_ready_i;
  logic [DW-1:0]  out_data_o;
  logic           busy_o, done_o;

  color_conv_engine #(.PIX_PER_BEAT(NP), .CH_WIDTH(CW), .COEF_WIDTH(KW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .mode_i(mode_i), .len_i(len_i), .coef_i(coef_i),
    .in_off_i(in_off_i), .out_off_i(out_off_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = -1, last_out_cyc = -1, in_hs_cnt = 0, busy_cnt = 0;
  logic [DW-1:0] got_q [$];
  logic [DW-1:0] beats [16];
  int mc [9];
  int mio [3];
  int moo [3];
  int cust_c [9];
  int cust_io [3];
  int cust_oo [3];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (out_valid_o && out_ready_i) begin
      got_q.push_back(out_data_o);
      last_out_cyc = cyc;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (in_valid_i && in_ready_o) in_hs_cnt++;
    if (busy_o) busy_cnt++;
  end

  function automatic logic [DW-1:0] refBeat(input logic [DW-1:0] din);
    logic [DW-1:0] r;
    int x [3];
    int acc, y;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      for (int k = 0; k < 3; k++) x[k] = int'(din[(3*p+k)*CW +: CW]);
      for (int row = 0; row < 3; row++) begin
        acc = 128;
        for (int k = 0; k < 3; k++) acc += mc[3*row+k] * (x[k] + mio[k]);
        y = (acc >>> 8) + moo[row];
        if (y < 0) y = 0;
        if (y > 255) y = 255;
        r[(3*p+row)*CW +: CW] = y[CW-1:0];
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) beats[i] = {$urandom, $urandom, $urandom};
  endtask

  // Programs a job and loads the matching reference parameters.
  task automatic applyStimulus(input int mode, input int len);
    case (mode)
      0: begin mc = '{256, 0, 0, 0, 256, 0, 0, 0, 256}; mio = '{0, 0, 0}; moo = '{0, 0, 0}; end
      1: begin mc = '{77, 150, 29, -43, -85, 128, 128, -107, -21}; mio = '{0, 0, 0}; moo = '{0, 128, 128}; end
      2: begin mc = '{256, 0, 359, 256, -88, -183, 256, 454, 0}; mio = '{0, -128, -128}; moo = '{0, 0, 0}; end
      default: begin mc = cust_c; mio = cust_io; moo = cust_oo; end
    endcase
    for (int i = 0; i < 9; i++) coef_i[i*KW +: KW] = KW'(cust_c[i]);
    for (int k = 0; k < 3; k++) begin
      in_off_i[k*OW +: OW]  = OW'(cust_io[k]);
      out_off_i[k*OW +: OW] = OW'(cust_oo[k]);
    end
    mode_i  = 2'(mode);
    len_i   = LW'(len);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Streams beats[0..n-1], optionally stalls the sink once output appears, optionally
  // pulses a foreign start after glitch_at accepted beats, then checks the job result.
  task automatic runJob(input int n, input int stall_len, input int glitch_at);
    int base, dbase, sent, stall_left, budget;
    bit stall_used, acc, first_hold, seen_done;
    logic [DW-1:0] held;
    base = got_q.size(); dbase = done_cnt; sent = 0; stall_left = 0; budget = 0;
    stall_used = 0; first_hold = 1; seen_done = 0; held = '0;
    in_valid_i = 1'b1;
    in_data_i  = beats[0];
    while (!seen_done && budget < 300) begin
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o;
      if (!out_ready_i) begin
        checkOutput("stall_in_ready", DW'(in_ready_o), '0);
        if (first_hold) begin
          held = out_data_o;
          first_hold = 0;
        end else checkOutput("stall_hold_data", out_data_o, held);
      end
      tick();
      budget++;
      start_i = 1'b0;
      if (acc) begin
        sent++;
        if (sent < n) in_data_i = beats[sent];
        else in_valid_i = 1'b0;
        if (sent == glitch_at) begin
          start_i = 1'b1; mode_i = 2'd2; len_i = LW'(5);
        end
      end
      if (stall_len > 0 && !stall_used && out_valid_o) begin
        out_ready_i = 1'b0; stall_left = stall_len; stall_used = 1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready_i = 1'b1;
      end
      if (done_cnt != dbase) seen_done = 1;
    end
    out_ready_i = 1'b1; in_valid_i = 1'b0; start_i = 1'b0;
    checkOutput("job_completes", DW'(seen_done), DW'(1));
    repeat (3) tick();
    checkOutput("out_count", DW'(got_q.size() - base), DW'(n));
    for (int i = 0; i < n; i++)
      if (base + i < got_q.size()) checkOutput("beat_vs_model", got_q[base+i], refBeat(beats[i]));
    checkOutput("done_once", DW'(done_cnt - dbase), DW'(1));
    checkOutput("done_after_last_out", DW'(done_cyc), DW'(last_out_cyc + 1));
  endtask

  initial begin
    int b, dbase, hbase, bbase, scyc, budget;
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; mode_i = '0; len_i = '0;
    coef_i = '0; in_off_i = '0; out_off_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b1;
    cust_c = '{0, 0, 0, 0, 0, 0, 0, 0, 0}; cust_io = '{0, 0, 0}; cust_oo = '{0, 0, 0};
    repeat (3) tick();
    checkOutput("reset_in_ready", DW'(in_ready_o), '0);
    checkOutput("reset_out_valid", DW'(out_valid_o), '0);
    checkOutput("reset_out_data", out_data_o, '0);
    checkOutput("reset_busy", DW'(busy_o), '0);
    checkOutput("reset_done", DW'(done_o), '0);
    rst_i = 1'b0;
    tick();

    $display("[TB] mode 1 directed");
    beats[0] = {4{24'hFFFFFF}};
    beats[1] = {4{24'h0000FF}};
    b = got_q.size();
    applyStimulus(1, 2);
    runJob(2, 0, -1);
    checkOutput("m1_white", got_q[b], {4{24'h8080FF}});
    checkOutput("m1_red_cr_sat", got_q[b+1], {4{24'hFF554D}});

    $display("[TB] mode 2 directed");
    beats[0] = {4{24'h808080}};
    beats[1] = {4{24'hFF80FF}};
    b = got_q.size();
    applyStimulus(2, 2);
    runJob(2, 0, -1);
    checkOutput("m2_grey", got_q[b], {4{24'h808080}});
    checkOutput("m2_r_sat", got_q[b+1], {4{24'hFFA4FF}});

    $display("[TB] mode 3 zero matrix");
    cust_io = '{-3, 100, -256};
    cust_oo = '{10, -5, 255};
    fillRandom(2);
    b = got_q.size();
    applyStimulus(3, 2);
    runJob(2, 0, -1);
    checkOutput("m3_offsets_only", got_q[b], {4{24'hFF000A}});
    checkOutput("m3_offsets_only_b1", got_q[b+1], {4{24'hFF000A}});

    $display("[TB] mode 3 random matrix");
    for (int i = 0; i < 9; i++) cust_c[i] = int'($urandom_range(1023)) - 512;
    for (int k = 0; k < 3; k++) begin
      cust_io[k] = int'($urandom_range(511)) - 256;
      cust_oo[k] = int'($urandom_range(511)) - 256;
    end
    fillRandom(6);
    applyStimulus(3, 6);
    runJob(6, 0, -1);

    $display("[TB] bypass with backpressure");
    fillRandom(8);
    b = got_q.size();
    applyStimulus(0, 8);
    runJob(8, 5, -1);
    for (int i = 0; i < 8; i++) checkOutput("bypass_identity", got_q[b+i], beats[i]);

    $display("[TB] empty job");
    dbase = done_cnt; hbase = in_hs_cnt; bbase = busy_cnt;
    in_valid_i = 1'b1; in_data_i = beats[0];
    scyc = cyc;
    applyStimulus(0, 0);
    repeat (5) tick();
    in_valid_i = 1'b0;
    checkOutput("len0_done_once", DW'(done_cnt - dbase), DW'(1));
    checkOutput("len0_done_timing", DW'(done_cyc), DW'(scyc + 2));
    checkOutput("len0_no_handshake", DW'(in_hs_cnt - hbase), '0);
    checkOutput("len0_not_busy", DW'(busy_cnt - bbase), '0);

    $display("[TB] start ignored while running");
    fillRandom(3);
    applyStimulus(1, 3);
    runJob(3, 0, 1);

    $display("[TB] clear during drain");
    fillRandom(3);
    applyStimulus(0, 3);
    hbase = in_hs_cnt;
    in_valid_i = 1'b1; in_data_i = beats[0];
    budget = 0;
    while (in_hs_cnt - hbase < 3 && budget < 50) begin
      @(negedge clk_i);
      tick();
      budget++;
      in_data_i = beats[(in_hs_cnt - hbase) % 3];
    end
    in_valid_i = 1'b0;
    checkOutput("clear_setup_accepts", DW'(in_hs_cnt - hbase), DW'(3));
    dbase = done_cnt;
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checkOutput("clear_out_valid", DW'(out_valid_o), '0);
    checkOutput("clear_busy", DW'(busy_o), '0);
    repeat (6) tick();
    checkOutput("clear_no_done", DW'(done_cnt - dbase), '0);
    fillRandom(4);
    applyStimulus(1, 4);
    runJob(4, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
